// File: rtl/script_branch_unit.sv
// Conditional-branch and wait-for-signal resolver for the kitchen script interpreter.
// Resolves jumpif/jumpifn/loopif/waitfor and returns the next PC through a start/done handshake.
module script_branch_unit #(
  parameter int PC_W        = 8,
  parameter int OFF_W       = 8,
  parameter int SIG_N       = 8,
  parameter int SEL_W       = 3,
  parameter int INSTR_BYTES = 2,
  parameter int TMO_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       func,
  input  logic [OFF_W-1:0] i_num,
  input  logic [SEL_W-1:0] i_sign,
  input  logic [PC_W-1:0]  current_pc,
  input  logic [SIG_N-1:0] feedback_sig,
  input  logic [TMO_W-1:0] timeout,
  output logic             busy,
  output logic             done,
  output logic [PC_W-1:0]  next_pc,
  output logic             taken,
  output logic             timed_out
);

  localparam int EXT_W = PC_W + OFF_W + 2;
  localparam int SIG_X = ((1 << SEL_W) > SIG_N) ? (1 << SEL_W) : SIG_N;

  localparam logic [1:0] F_JIF  = 2'b00;
  localparam logic [1:0] F_JIFN = 2'b01;
  localparam logic [1:0] F_LOOP = 2'b10;
  localparam logic [1:0] F_WAIT = 2'b11;

  typedef enum logic [1:0] {IDLE, EVAL, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       func_q;
  logic [OFF_W-1:0] num_q;
  logic [SEL_W-1:0] sign_q;
  logic [PC_W-1:0]  pc_q;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] cnt, cnt_nxt;
  logic [PC_W-1:0]  next_pc_nxt;
  logic             taken_nxt, timed_out_nxt;

  logic [SIG_X-1:0] sig_ext;
  logic             sig_sel;
  logic [EXT_W-1:0] pc_ext, step_ext;
  logic [PC_W-1:0]  pc_fall, pc_fwd, pc_back;
  logic             expire;

  // PC arithmetic is done wide, then wrapped modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_wrap(input logic [EXT_W-1:0] v);
    return PC_W'(v);
  endfunction

  // Selectors beyond SIG_N land on zero-filled bits, so s reads as 0.
  assign sig_ext  = SIG_X'(feedback_sig);
  assign sig_sel  = sig_ext[sign_q];

  assign pc_ext   = EXT_W'(pc_q);
  assign step_ext = EXT_W'(INSTR_BYTES) * EXT_W'(num_q);
  assign pc_fall  = pc_wrap(pc_ext + EXT_W'(INSTR_BYTES));
  assign pc_fwd   = pc_wrap(pc_ext + step_ext);
  assign pc_back  = pc_wrap(pc_ext - step_ext);

  assign expire   = (tmo_q != '0) && (cnt == tmo_q - TMO_W'(1));

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt     = state;
    next_pc_nxt   = next_pc;
    taken_nxt     = taken;
    timed_out_nxt = timed_out;
    cnt_nxt       = cnt;
    case (state)
      IDLE: if (start) state_nxt = EVAL;
      EVAL: begin
        if (func_q == F_WAIT) begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end else begin
          taken_nxt     = (func_q == F_JIFN) ? ~sig_sel : sig_sel;
          timed_out_nxt = 1'b0;
          if (!taken_nxt)            next_pc_nxt = pc_fall;
          else if (func_q == F_LOOP) next_pc_nxt = pc_back;
          else                       next_pc_nxt = pc_fwd;
          state_nxt = DONE;
        end
      end
      WAIT: begin
        // Signal has priority over a simultaneous timeout expiry.
        if (sig_sel) begin
          next_pc_nxt   = pc_fall;
          taken_nxt     = 1'b0;
          timed_out_nxt = 1'b0;
          state_nxt     = DONE;
        end else if (expire) begin
          next_pc_nxt   = pc_fwd;
          taken_nxt     = 1'b1;
          timed_out_nxt = 1'b1;
          state_nxt     = DONE;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + TMO_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      next_pc   <= '0;
      taken     <= 1'b0;
      timed_out <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      next_pc   <= next_pc_nxt;
      taken     <= taken_nxt;
      timed_out <= timed_out_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Operands are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      func_q <= func;
      num_q  <= i_num;
      sign_q <= i_sign;
      pc_q   <= current_pc;
      tmo_q  <= timeout;
    end
  end

endmodule

// File: tb/tb_script_branch_unit.sv
// Directed bench for script_branch_unit: table of branch/wait vectors plus
// hand-written sequences for busy-start rejection and reset during WAIT.
module tb_script_branch_unit;
  localparam int PC_W = 8, OFF_W = 8, SIG_N = 8, SEL_W = 4, INSTR_BYTES = 2, TMO_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       func = '0;
  logic [OFF_W-1:0] i_num = '0;
  logic [SEL_W-1:0] i_sign = '0;
  logic [PC_W-1:0]  current_pc = '0;
  logic [SIG_N-1:0] feedback_sig = '0;
  logic [TMO_W-1:0] timeout = '0;
  logic             busy, done, taken, timed_out;
  logic [PC_W-1:0]  next_pc;

  always #5 clk = ~clk;

  script_branch_unit #(
    .PC_W(PC_W), .OFF_W(OFF_W), .SIG_N(SIG_N), .SEL_W(SEL_W),
    .INSTR_BYTES(INSTR_BYTES), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .i_num(i_num),
    .i_sign(i_sign), .current_pc(current_pc), .feedback_sig(feedback_sig),
    .timeout(timeout), .busy(busy), .done(done), .next_pc(next_pc),
    .taken(taken), .timed_out(timed_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      nm;
    logic [1:0] f;
    int         num;
    int         sel;
    int         pc;
    logic [7:0] fb;
    int         tmo;
    int         rise;  // WAIT cycle in which feedback_sig[sel] goes high, 0 = never
    int         epc;
    int         etk;
    int         eto;
    int         lat;   // cycles from accepting edge to done cycle
  } vec_t;

  vec_t vecs[$];

  task automatic run(input vec_t v);
    int n;
    int busy_ok;
    int got;
    @(negedge clk);
    func = v.f; i_num = OFF_W'(v.num); i_sign = SEL_W'(v.sel);
    current_pc = PC_W'(v.pc); feedback_sig = v.fb; timeout = TMO_W'(v.tmo);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    func = ~v.f; i_num = 8'hA5; current_pc = 8'h5A; timeout = 16'd3;
    i_sign = SEL_W'(v.sel ^ 1);
    n = 0; busy_ok = 1; got = 0;
    while (got == 0 && n < 1100) begin
      @(negedge clk);
      n++;
      if (!busy) busy_ok = 0;
      if (done) got = 1;
      else if (v.rise != 0 && n == v.rise + 1) feedback_sig[v.sel] = 1'b1;
    end
    chk({v.nm, " latency"}, n, v.lat);
    chk({v.nm, " busy"}, busy_ok, 1);
    chk({v.nm, " next_pc"}, int'(next_pc), v.epc);
    chk({v.nm, " taken"}, int'(taken), v.etk);
    chk({v.nm, " timed_out"}, int'(timed_out), v.eto);
    @(negedge clk);
    chk({v.nm, " done after"}, int'(done), 0);
    chk({v.nm, " busy after"}, int'(busy), 0);
  endtask

  initial begin
    int ndone;
    int seen_pc;

    vecs.push_back('{"jif_taken",   2'b00, 3,   2, 10,  8'h04, 0, 0, 16,  1, 0, 2});
    vecs.push_back('{"jifn_fall",   2'b01, 3,   2, 10,  8'h04, 0, 0, 12,  0, 0, 2});
    vecs.push_back('{"loop_back",   2'b10, 4,   5, 20,  8'h20, 0, 0, 12,  1, 0, 2});
    vecs.push_back('{"loop_wrap",   2'b10, 4,   5, 4,   8'h20, 0, 0, 252, 1, 0, 2});
    vecs.push_back('{"jif_wrap",    2'b00, 5,   0, 250, 8'h01, 0, 0, 4,   1, 0, 2});
    vecs.push_back('{"sel_oor",     2'b01, 1,   9, 0,   8'hFF, 0, 0, 2,   1, 0, 2});
    vecs.push_back('{"loop_fall",   2'b10, 3,   7, 100, 8'h7F, 0, 0, 102, 0, 0, 2});
    vecs.push_back('{"jif_fallwrap",2'b00, 200, 3, 255, 8'hF7, 0, 0, 1,   0, 0, 2});
    vecs.push_back('{"jif_bigoff",  2'b00, 255, 3, 0,   8'h08, 0, 0, 254, 1, 0, 2});
    vecs.push_back('{"loop_bigoff", 2'b10, 255, 3, 0,   8'h08, 0, 0, 2,   1, 0, 2});
    vecs.push_back('{"wait_sig3",   2'b11, 2,   1, 30,  8'h00, 5, 3, 32,  0, 0, 5});
    vecs.push_back('{"wait_tmo5",   2'b11, 2,   1, 30,  8'h00, 5, 0, 34,  1, 1, 7});
    vecs.push_back('{"jif_zero",    2'b00, 0,   0, 0,   8'h01, 0, 0, 0,   1, 0, 2});
    vecs.push_back('{"wait_tie",    2'b11, 2,   1, 30,  8'h00, 5, 5, 32,  0, 0, 7});
    vecs.push_back('{"wait_tmo1",   2'b11, 1,   1, 40,  8'h00, 1, 0, 42,  1, 1, 3});
    vecs.push_back('{"wait_sig1",   2'b11, 1,   1, 50,  8'h00, 7, 1, 52,  0, 0, 3});
    vecs.push_back('{"wait_inf",    2'b11, 3,   1, 60,  8'h00, 0, 1000, 62, 0, 0, 1002});

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst next_pc", int'(next_pc), 0);
    chk("rst taken", int'(taken), 0);
    chk("rst timed_out", int'(timed_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run(vecs[i]);

    // Start pulsed while busy is ignored: exactly one done with the waitfor result
    @(negedge clk);
    func = 2'b11; i_num = 8'd4; i_sign = 4'd2; current_pc = 8'd70;
    timeout = 16'd0; feedback_sig = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    func = 2'b00; i_num = 8'd1; i_sign = 4'd0; current_pc = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busystart busy", int'(busy), 1);
    feedback_sig[2] = 1'b1;
    ndone = 0; seen_pc = -1;
    repeat (10) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        seen_pc = int'(next_pc);
      end
    end
    chk("busystart done count", ndone, 1);
    chk("busystart next_pc", seen_pc, 72);
    chk("busystart taken", int'(taken), 0);
    feedback_sig = 8'h00;

    // Reset during WAIT discards the operation
    run('{"pre_rst", 2'b00, 1, 0, 9, 8'h01, 0, 0, 11, 1, 0, 2});
    @(negedge clk);
    func = 2'b11; i_num = 8'd5; i_sign = 4'd2; current_pc = 8'd80;
    timeout = 16'd0; feedback_sig = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstwait busy before", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstwait busy", int'(busy), 0);
    chk("rstwait done", int'(done), 0);
    chk("rstwait next_pc", int'(next_pc), 0);
    chk("rstwait taken", int'(taken), 0);
    chk("rstwait timed_out", int'(timed_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    feedback_sig[2] = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rstwait no activity", ndone, 0);
    feedback_sig = 8'h00;
    run(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
